// File: rtl/rwl_decode_ctrl_if.sv
// Request/response bus between a read requester and rwl_decode_ctrl.
// rd_addr_par exists only when RWL_ADDR_PARITY_EN is defined.
interface rwl_decode_ctrl_if #(
    parameter int ADDR_W   = 8,
    parameter int NUM_ROWS = 256
);
    logic                rd_req;
    logic [ADDR_W-1:0]   rd_addr;
`ifdef RWL_ADDR_PARITY_EN
    logic                rd_addr_par;
`endif
    logic                rd_rdy;
    logic [NUM_ROWS-1:0] rwl;
    logic                rd_done;
    logic                rd_err;

    modport master (
        output rd_req, rd_addr,
`ifdef RWL_ADDR_PARITY_EN
        output rd_addr_par,
`endif
        input  rd_rdy, rwl, rd_done, rd_err
    );

    modport slave (
        input  rd_req, rd_addr,
`ifdef RWL_ADDR_PARITY_EN
        input  rd_addr_par,
`endif
        output rd_rdy, rwl, rd_done, rd_err
    );
endinterface

// File: rtl/rwl_decode_ctrl.sv
// Read-wordline decoder/timer: registered one-hot RWL pulse followed by an all-zero gap.
// Optional macro RWL_ADDR_PARITY_EN adds an even-parity check of rd_addr on accept.
module rwl_decode_ctrl #(
    parameter int ADDR_W    = 8,
    parameter int NUM_ROWS  = 256,
    parameter int PULSE_CYC = 2,
    parameter int REC_CYC   = 1
) (
    input logic              clk,
    input logic              rst,
    rwl_decode_ctrl_if.slave bus
);
    localparam int MAX_CYC = (PULSE_CYC > REC_CYC) ? PULSE_CYC : REC_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [ADDR_W:0] ROW_LIM = (ADDR_W+1)'(NUM_ROWS);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, RECOVER} state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   addr_q;
    logic                bad_q, bad_in, accept, cnt_zero;
    logic [NUM_ROWS-1:0] rwl_d, rwl_q;
    logic                done_d, err_d, done_q, err_q;

    assign accept   = bus.rd_req && (state == IDLE);
    assign cnt_zero = (cnt == '0);

`ifdef RWL_ADDR_PARITY_EN
    assign bad_in = ({1'b0, bus.rd_addr} >= ROW_LIM) || ((^bus.rd_addr) != bus.rd_addr_par);
`else
    assign bad_in = ({1'b0, bus.rd_addr} >= ROW_LIM);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = PULSE;
            PULSE:   if (cnt_zero) state_nxt = RECOVER;
            RECOVER: if (cnt_zero) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are decoded from the state and then registered, so RWL/done/err
    // trail the state by one cycle and RWL comes straight from flops.
    always_comb begin
        rwl_d = '0;
        for (int i = 0; i < NUM_ROWS; i++)
            rwl_d[i] = (state == PULSE) && !bad_q && (addr_q == ADDR_W'(i));
        done_d = (state == RECOVER) && cnt_zero;
        err_d  = done_d && bad_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            addr_q <= '0;
            bad_q  <= 1'b0;
            rwl_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            rwl_q  <= rwl_d;
            done_q <= done_d;
            err_q  <= err_d;
            if (accept) begin
                addr_q <= bus.rd_addr;
                bad_q  <= bad_in;
            end
            // Reloaded on entry to PULSE and RECOVER; never wraps.
            case (state)
                SETUP:   cnt <= CNT_W'(PULSE_CYC - 1);
                PULSE:   cnt <= cnt_zero ? CNT_W'(REC_CYC - 1) : cnt - CNT_W'(1);
                RECOVER: if (!cnt_zero) cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign bus.rd_rdy  = (state == IDLE);
    assign bus.rwl     = rwl_q;
    assign bus.rd_done = done_q;
    assign bus.rd_err  = err_q;
endmodule

// File: tb/tb_rwl_decode_ctrl.sv
// Bench for rwl_decode_ctrl: two instances (256 rows and 200 rows) checked against a
// timing model that predicts outputs from each accept time with plain arithmetic.
module tb_rwl_decode_ctrl;
    localparam int P = 2;
    localparam int R = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rwl_decode_ctrl_if #(.ADDR_W(8), .NUM_ROWS(256)) ifa ();
    rwl_decode_ctrl_if #(.ADDR_W(8), .NUM_ROWS(200)) ifb ();

    rwl_decode_ctrl #(.ADDR_W(8), .NUM_ROWS(256), .PULSE_CYC(P), .REC_CYC(R))
        dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    rwl_decode_ctrl #(.ADDR_W(8), .NUM_ROWS(200), .PULSE_CYC(P), .REC_CYC(R))
        dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

    logic       req  [2];
    logic [7:0] addr [2];
    assign ifa.rd_req  = req[0];
    assign ifa.rd_addr = addr[0];
    assign ifb.rd_req  = req[1];
    assign ifb.rd_addr = addr[1];
`ifdef RWL_ADDR_PARITY_EN
    logic par [2];
    assign ifa.rd_addr_par = par[0];
    assign ifb.rd_addr_par = par[1];
`endif

    logic [255:0] o_rwl  [2];
    logic         o_rdy  [2];
    logic         o_done [2];
    logic         o_err  [2];
    assign o_rwl[0]  = ifa.rwl;
    assign o_rwl[1]  = {56'd0, ifb.rwl};
    assign o_rdy[0]  = ifa.rd_rdy;
    assign o_rdy[1]  = ifb.rd_rdy;
    assign o_done[0] = ifa.rd_done;
    assign o_done[1] = ifb.rd_done;
    assign o_err[0]  = ifa.rd_err;
    assign o_err[1]  = ifb.rd_err;

    int checks = 0;
    int errors = 0;

    // Model: the cycle of the latest accept fixes every output of that transaction.
    int         cyc = 0;
    int         t_acc [2];
    logic [7:0] a_acc [2];
    bit         ok_acc[2];

    function automatic bit m_rdy(int d, int c);
        return c >= t_acc[d] + P + R + 1;
    endfunction
    function automatic logic [255:0] m_rwl(int d, int c);
        logic [255:0] v = '0;
        if (ok_acc[d] && c >= t_acc[d] + 2 && c <= t_acc[d] + 1 + P) v[a_acc[d]] = 1'b1;
        return v;
    endfunction
    function automatic bit m_done(int d, int c);
        return c == t_acc[d] + 1 + P + R;
    endfunction
    function automatic bit m_err(int d, int c);
        return m_done(d, c) && !ok_acc[d];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) t_acc[d] = -1000;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        for (int d = 0; d < 2; d++)
            if (!rst && req[d] && m_rdy(d, cyc - 1)) begin
                t_acc[d]  = cyc;
                a_acc[d]  = addr[d];
                ok_acc[d] = int'(addr[d]) < ((d == 0) ? 256 : 200);
`ifdef RWL_ADDR_PARITY_EN
                ok_acc[d] = ok_acc[d] && (par[d] == ^addr[d]);
`endif
            end
        #1;
    endtask

    task automatic set_in(logic r, logic [7:0] a);
        for (int d = 0; d < 2; d++) begin
            req[d]  = r;
            addr[d] = a;
`ifdef RWL_ADDR_PARITY_EN
            par[d]  = ^a;
`endif
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        set_in(1'b0, 8'd0);
        for (int k = 0; k < 7; k++) begin
            if (k == 2) rst = 1'b0;
            tick();
            for (int d = 0; d < 2; d++) begin
                if (o_rwl[d] !== '0) begin errors++; $display("FAIL reset_rwl dut%0d cyc %0d got %h", d, cyc, o_rwl[d]); end
                checks++;
                if (o_rdy[d] !== 1'b1) begin errors++; $display("FAIL reset_rdy dut%0d cyc %0d got %b exp 1", d, cyc, o_rdy[d]); end
                checks++;
                if (o_done[d] !== 1'b0 || o_err[d] !== 1'b0) begin
                    errors++; $display("FAIL reset_done dut%0d cyc %0d done %b err %b exp 0 0", d, cyc, o_done[d], o_err[d]);
                end
                checks++;
            end
        end
    endtask

    // Drives one request at (a) for a single cycle and checks the following n cycles.
    task automatic run_single(string name, logic [7:0] a, bit bad_par, int n);
        set_in(1'b1, a);
`ifdef RWL_ADDR_PARITY_EN
        for (int d = 0; d < 2; d++) par[d] = par[d] ^ bad_par;
`else
        if (bad_par) $display("note: parity not built, %s runs with correct parity", name);
`endif
        for (int k = 0; k < n; k++) begin
            tick();
            if (k == 0) set_in(1'b0, a);
            for (int d = 0; d < 2; d++) begin
                if (o_rwl[d] !== m_rwl(d, cyc)) begin errors++; $display("FAIL %s_rwl dut%0d cyc %0d got %h exp %h", name, d, cyc, o_rwl[d], m_rwl(d, cyc)); end
                checks++;
                if (o_rdy[d] !== m_rdy(d, cyc)) begin errors++; $display("FAIL %s_rdy dut%0d cyc %0d got %b exp %b", name, d, cyc, o_rdy[d], m_rdy(d, cyc)); end
                checks++;
                if (o_done[d] !== m_done(d, cyc)) begin errors++; $display("FAIL %s_done dut%0d cyc %0d got %b exp %b", name, d, cyc, o_done[d], m_done(d, cyc)); end
                checks++;
                if (o_err[d] !== m_err(d, cyc)) begin errors++; $display("FAIL %s_err dut%0d cyc %0d got %b exp %b", name, d, cyc, o_err[d], m_err(d, cyc)); end
                checks++;
            end
        end
    endtask

    task automatic test_single();
        run_single("single37", 8'd37, 1'b0, 7);
    endtask

    task automatic test_out_of_range();
        run_single("oor210", 8'd210, 1'b0, 7);
    endtask

    task automatic test_back_to_back();
        set_in(1'b1, 8'd0);
        for (int k = 0; k < 14; k++) begin
            tick();
            if (cyc == t_acc[0] && a_acc[0] == 8'd0) set_in(1'b1, 8'd255);
            else if (cyc == t_acc[0] && a_acc[0] == 8'd255) set_in(1'b0, 8'd255);
            for (int d = 0; d < 2; d++) begin
                if (o_rwl[d] !== m_rwl(d, cyc)) begin errors++; $display("FAIL b2b_rwl dut%0d cyc %0d got %h exp %h", d, cyc, o_rwl[d], m_rwl(d, cyc)); end
                checks++;
                if ($countones(o_rwl[d]) > 1) begin errors++; $display("FAIL b2b_onehot dut%0d cyc %0d got %0d bits exp <=1", d, cyc, $countones(o_rwl[d])); end
                checks++;
                if (o_rdy[d] !== m_rdy(d, cyc)) begin errors++; $display("FAIL b2b_rdy dut%0d cyc %0d got %b exp %b", d, cyc, o_rdy[d], m_rdy(d, cyc)); end
                checks++;
                if (o_done[d] !== m_done(d, cyc) || o_err[d] !== m_err(d, cyc)) begin
                    errors++; $display("FAIL b2b_done dut%0d cyc %0d got %b%b exp %b%b", d, cyc, o_done[d], o_err[d], m_done(d, cyc), m_err(d, cyc));
                end
                checks++;
            end
        end
    endtask

    task automatic test_reset_mid();
        set_in(1'b1, 8'd100);
        tick();
        set_in(1'b0, 8'd100);
        tick();
        tick();
        if (o_rwl[0] !== m_rwl(0, cyc) || o_rwl[0][100] !== 1'b1) begin
            errors++; $display("FAIL mid_prepulse cyc %0d got %h exp bit 100", cyc, o_rwl[0]);
        end
        checks++;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) begin
            if (o_rwl[d] !== '0) begin errors++; $display("FAIL mid_async_rwl dut%0d got %h exp 0", d, o_rwl[d]); end
            checks++;
            if (o_rdy[d] !== 1'b1) begin errors++; $display("FAIL mid_async_rdy dut%0d got %b exp 1", d, o_rdy[d]); end
            checks++;
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                if (o_done[d] !== 1'b0 || o_rwl[d] !== '0 || o_rdy[d] !== 1'b1) begin
                    errors++; $display("FAIL mid_after dut%0d cyc %0d done %b rdy %b rwl %h exp 0 1 0", d, cyc, o_done[d], o_rdy[d], o_rwl[d]);
                end
                checks++;
            end
        end
    endtask

`ifdef RWL_ADDR_PARITY_EN
    task automatic test_parity();
        run_single("par_bad", 8'h03, 1'b1, 7);
        run_single("par_good", 8'h03, 1'b0, 7);
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            for (int d = 0; d < 2; d++) begin
                req[d]  = ($urandom_range(0, 3) != 0);
                addr[d] = 8'($urandom);
`ifdef RWL_ADDR_PARITY_EN
                par[d]  = (^addr[d]) ^ ($urandom_range(0, 7) == 0);
`endif
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                if (o_rwl[d] !== m_rwl(d, cyc)) begin errors++; $display("FAIL rnd_rwl dut%0d cyc %0d got %h exp %h", d, cyc, o_rwl[d], m_rwl(d, cyc)); end
                checks++;
                if (o_rdy[d] !== m_rdy(d, cyc)) begin errors++; $display("FAIL rnd_rdy dut%0d cyc %0d got %b exp %b", d, cyc, o_rdy[d], m_rdy(d, cyc)); end
                checks++;
                if (o_done[d] !== m_done(d, cyc)) begin errors++; $display("FAIL rnd_done dut%0d cyc %0d got %b exp %b", d, cyc, o_done[d], m_done(d, cyc)); end
                checks++;
                if (o_err[d] !== m_err(d, cyc)) begin errors++; $display("FAIL rnd_err dut%0d cyc %0d got %b exp %b", d, cyc, o_err[d], m_err(d, cyc)); end
                checks++;
            end
        end
        set_in(1'b0, 8'd0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            a_acc[d]  = 8'd0;
            ok_acc[d] = 1'b1;
        end
        test_reset();
        test_single();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid();
`ifdef RWL_ADDR_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
